// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the mapper/compositor chain and VGA connector.
// Latency: n/a (wires only). Backpressure: none, consumers sample every vga_clk.
// master = timing generator, slave = any consumer of position/sync.
interface vga_timing_gen_if;
   logic [9:0] DrawX;
   logic [9:0] DrawY;
   logic       blank;
   logic       hs;
   logic       vs;
   logic       line_start;
   logic       frame_start;
   logic       pix_en;

   modport master (
      output DrawX, DrawY, blank, hs, vs, line_start, frame_start, pix_en
   );

   modport slave (
      input  DrawX, DrawY, blank, hs, vs, line_start, frame_start, pix_en
   );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster position counter with blank/hsync/vsync/line/frame decode.
// Latency: every output is registered from the next position, so all levels match DrawX/DrawY of the same cycle.
// Backpressure: none, free-running; optional VGA_PIXEL_DIV2_EN advances position every second vga_clk edge.
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33
) (
   input  logic               vga_clk,
   input  logic               reset_n,
   vga_timing_gen_if.master   vga
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
   // 11-bit bounds so a window ending exactly at 1024 still compares correctly
   localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
   localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FP);
   localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
   localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FP);
   localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FP + V_SYNC);

   logic [9:0] x_q, y_q;
   logic [9:0] x_nxt, y_nxt;
   logic       pix_en_q, pix_en_nxt;
   logic       blank_q, hs_q, vs_q, line_start_q, frame_start_q;
   logic       blank_nxt, hs_nxt, vs_nxt, line_start_nxt, frame_start_nxt;
   logic [10:0] x_ext, y_ext;

   always_comb begin
      x_nxt = x_q;
      y_nxt = y_q;
      if (pix_en_q) begin
         if (x_q == H_LAST) begin
            x_nxt = '0;
            y_nxt = (y_q == V_LAST) ? '0 : y_q + 10'd1;
         end else begin
            x_nxt = x_q + 10'd1;
         end
      end
   end

`ifdef VGA_PIXEL_DIV2_EN
   assign pix_en_nxt = ~pix_en_q;
`else
   assign pix_en_nxt = 1'b1;
`endif

   // Decode the position that will be presented after this edge.
   always_comb begin
      x_ext           = {1'b0, x_nxt};
      y_ext           = {1'b0, y_nxt};
      blank_nxt       = (x_ext < H_VIS_END) && (y_ext < V_VIS_END);
      hs_nxt          = !((x_ext >= H_SYNC_BEG) && (x_ext < H_SYNC_END));
      vs_nxt          = !((y_ext >= V_SYNC_BEG) && (y_ext < V_SYNC_END));
      line_start_nxt  = (x_nxt == 10'd0);
      frame_start_nxt = (x_nxt == 10'd0) && (y_nxt == 10'd0);
   end

   // Reset parks on the last pixel of the frame so the first advance lands on (0,0).
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         x_q           <= H_LAST;
         y_q           <= V_LAST;
         pix_en_q      <= 1'b0;
         blank_q       <= 1'b0;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         x_q           <= x_nxt;
         y_q           <= y_nxt;
         pix_en_q      <= pix_en_nxt;
         blank_q       <= blank_nxt;
         hs_q          <= hs_nxt;
         vs_q          <= vs_nxt;
         line_start_q  <= line_start_nxt;
         frame_start_q <= frame_start_nxt;
      end
   end

   assign vga.DrawX       = x_q;
   assign vga.DrawY       = y_q;
   assign vga.blank       = blank_q;
   assign vga.hs          = hs_q;
   assign vga.vs          = vs_q;
   assign vga.line_start  = line_start_q;
   assign vga.frame_start = frame_start_q;
   assign vga.pix_en      = pix_en_q;

endmodule
